// File: rtl/imu_uart_framer_pkg.sv
// Shared constants, types and helpers for the IMU sample framer.
// Frame layout is AA 55, twelve data bytes, then a mod-256 checksum.
package imu_frame_pkg;

    localparam logic [7:0] HDR0 = 8'hAA;
    localparam logic [7:0] HDR1 = 8'h55;

    localparam int DATA_BYTES  = 12;
    localparam int FRAME_BYTES = 15;

    // Byte positions inside the transmitted frame.
    localparam logic [3:0] IDX_HDR0    = 4'd0;
    localparam logic [3:0] IDX_HDR1    = 4'd1;
    localparam logic [3:0] IDX_ACC_XH  = 4'd2;
    localparam logic [3:0] IDX_GYRO_ZL = 4'd13;
    localparam logic [3:0] IDX_CSUM    = 4'(FRAME_BYTES - 1);

    typedef logic [8*DATA_BYTES-1:0] sample_t;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        NEXT
    } state_t;

    function automatic logic [7:0] frame_checksum(sample_t d);
        logic [7:0] s;
        s = 8'h00;
        for (int k = 0; k < DATA_BYTES; k++) begin
            s = s + d[8*k +: 8];
        end
        return s;
    endfunction

    // Byte 0 of the sample (ACC_XH) lives in the top byte lane.
    function automatic logic [7:0] frame_byte(sample_t d, logic [7:0] cs,
                                              logic [3:0] i);
        logic [7:0] b;
        b = 8'h00;
        if (i == IDX_HDR0) begin
            b = HDR0;
        end else if (i == IDX_HDR1) begin
            b = HDR1;
        end else if (i == IDX_CSUM) begin
            b = cs;
        end else if (i >= IDX_ACC_XH && i <= IDX_GYRO_ZL) begin
            b = d[8*int'(IDX_GYRO_ZL - i) +: 8];
        end
        return b;
    endfunction

endpackage

// File: rtl/imu_uart_framer_if.sv
// Sample input and UART/status outputs of the IMU framer.
// master drives samples, slave is the framer itself.
interface imu_uart_framer_if;
    import imu_frame_pkg::*;

    logic       sample_valid;
    sample_t    sample_data;
    logic       uart_tx;
    logic       busy;
    logic [7:0] overrun_cnt;

    modport master (
        output sample_valid,
        output sample_data,
        input  uart_tx,
        input  busy,
        input  overrun_cnt
    );

    modport slave (
        input  sample_valid,
        input  sample_data,
        output uart_tx,
        output busy,
        output overrun_cnt
    );

endinterface

// File: rtl/imu_uart_framer_uart_tx_byte.sv
// 8N1 byte transmitter with a DIV-cycle bit period.
// done fires early so a chained start lands right after the stop bit.
module uart_tx_byte #(
    parameter int DIV = 434
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] data,
    output logic       tx,
    output logic       done
);

    localparam int CW = $clog2(DIV);

    logic [CW-1:0] cnt_q;
    logic [3:0]    bit_q;
    logic [9:0]    sh_q;
    logic          act_q;
    logic          tx_q;
    logic          done_q;
    logic          last;

    assign last = act_q && bit_q == 4'd9 && cnt_q == CW'(DIV - 1);
    assign tx   = tx_q;
    assign done = done_q;

    // Bit timer and shift register; a start in the stop bit's last cycle chains.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            bit_q  <= 4'd0;
            sh_q   <= '1;
            act_q  <= 1'b0;
            tx_q   <= 1'b1;
            done_q <= 1'b0;
        end else begin
            done_q <= act_q && bit_q == 4'd9 && cnt_q == CW'(DIV - 3);
            if (start && (!act_q || last)) begin
                sh_q  <= {1'b1, data, 1'b0};
                tx_q  <= 1'b0;
                cnt_q <= '0;
                bit_q <= 4'd0;
                act_q <= 1'b1;
            end else if (act_q) begin
                if (cnt_q == CW'(DIV - 1)) begin
                    cnt_q <= '0;
                    if (bit_q == 4'd9) begin
                        act_q <= 1'b0;
                        bit_q <= 4'd0;
                        tx_q  <= 1'b1;
                    end else begin
                        bit_q <= bit_q + 4'd1;
                        tx_q  <= sh_q[1];
                        sh_q  <= {1'b1, sh_q[9:1]};
                    end
                end else begin
                    cnt_q <= cnt_q + CW'(1);
                end
            end
        end
    end

endmodule

// File: rtl/imu_uart_framer.sv
// Frames 12-byte IMU samples into 15-byte UART frames.
// A one-deep shadow absorbs a sample arriving mid-frame.
module imu_uart_framer
    import imu_frame_pkg::*;
#(
    parameter int CLK_HZ = 50_000_000,
    parameter int BAUD   = 115200
) (
    input logic clk,
    input logic rst,
    imu_uart_framer_if.slave bus
);

    localparam int DIV = (CLK_HZ + BAUD / 2) / BAUD;

    state_t     state_q, state_d;
    logic [3:0] idx_q, idx_d;
    logic       launch_q, launch_d;
    sample_t    act_q, act_d;
    logic [7:0] csum_q, csum_d;
    sample_t    sh_q, sh_d;
    logic       sh_full_q, sh_full_d;
    logic       busy_q, busy_d;
    logic [7:0] ovr_q, ovr_d;

    logic       v;
    logic       ld_new;
    logic       pop;
    logic       last_byte;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx_done;
    logic       tx_line;

    assign v         = bus.sample_valid;
    assign last_byte = state_q == NEXT && idx_q == IDX_CSUM;

    uart_tx_byte #(
        .DIV(DIV)
    ) u_tx (
        .clk  (clk),
        .rst  (rst),
        .start(tx_start),
        .data (tx_data),
        .tx   (tx_line),
        .done (tx_done)
    );

    // FSM state and byte index register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // Next state; a fresh strobe at frame end with no shadow chains directly.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        ld_new  = 1'b0;
        pop     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (v) begin
                    state_d = SEND;
                    idx_d   = 4'd0;
                    ld_new  = 1'b1;
                end
            end
            SEND: begin
                if (tx_done) begin
                    state_d = NEXT;
                end
            end
            NEXT: begin
                if (idx_q != IDX_CSUM) begin
                    idx_d   = idx_q + 4'd1;
                    state_d = SEND;
                end else if (sh_full_q) begin
                    pop     = 1'b1;
                    idx_d   = 4'd0;
                    state_d = SEND;
                end else if (v) begin
                    ld_new  = 1'b1;
                    idx_d   = 4'd0;
                    state_d = SEND;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Byte launch: first byte after capture, later ones from NEXT.
    always_comb begin
        tx_start = launch_q;
        tx_data  = HDR0;
        if (state_q == NEXT) begin
            if (idx_q != IDX_CSUM) begin
                tx_start = 1'b1;
                tx_data  = frame_byte(act_q, csum_q, idx_q + 4'd1);
            end else begin
                tx_start = sh_full_q || v;
            end
        end
    end

    // Active/shadow buffers, busy flag and saturating overrun counter.
    always_comb begin
        launch_d  = state_q == IDLE && v;
        act_d     = act_q;
        csum_d    = csum_q;
        sh_d      = sh_q;
        sh_full_d = sh_full_q;
        ovr_d     = ovr_q;
        if (ld_new) begin
            act_d  = bus.sample_data;
            csum_d = frame_checksum(bus.sample_data);
        end else if (pop) begin
            act_d  = sh_q;
            csum_d = frame_checksum(sh_q);
        end
        if (pop) begin
            sh_full_d = 1'b0;
        end
        if (v && state_q != IDLE && !ld_new) begin
            sh_d      = bus.sample_data;
            sh_full_d = 1'b1;
            if (sh_full_q && !pop && ovr_q != 8'hFF) begin
                ovr_d = ovr_q + 8'd1;
            end
        end
        busy_d = launch_q || (busy_q && !(last_byte && !sh_full_q && !v));
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            launch_q  <= 1'b0;
            act_q     <= '0;
            csum_q    <= 8'h00;
            sh_q      <= '0;
            sh_full_q <= 1'b0;
            busy_q    <= 1'b0;
            ovr_q     <= 8'h00;
        end else begin
            launch_q  <= launch_d;
            act_q     <= act_d;
            csum_q    <= csum_d;
            sh_q      <= sh_d;
            sh_full_q <= sh_full_d;
            busy_q    <= busy_d;
            ovr_q     <= ovr_d;
        end
    end

    assign bus.uart_tx     = tx_line;
    assign bus.busy        = busy_q;
    assign bus.overrun_cnt = ovr_q;

endmodule
